// File: rtl/cap_touch_scanner_pkg.sv
// ---------------------------------------------------------------------------
// cap_touch_scanner_pkg
//   Shared constants and types for the capacitive pad scanner.
//   - Pad count, rise-time counter width, discharge/timeout timing,
//     touch threshold and debounce depth.
//   - FSM state encoding (IDLE=0, DISCHARGE=1, MEASURE=2, EVAL=3), also
//     visible on the scanner's fsm_state debug output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package cap_touch_scanner_pkg;

    localparam int NUM_SENSORS      = 9;
    localparam int CNT_W            = 12;
    localparam int DISCHARGE_CYCLES = 64;
    localparam int TIMEOUT_CYCLES   = 4000;  // must stay below 2**CNT_W
    localparam int THRESHOLD        = 200;   // rise count strictly above = touched
    localparam int DEBOUNCE_SCANS   = 3;

    localparam int DIS_W   = $clog2(DISCHARGE_CYCLES);
    localparam int AGREE_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISCHARGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_EVAL      = 2'd3
    } cap_state_t;

    // A pad counts as touched this scan when its rise time exceeds THRESHOLD.
    // The rise count already contains the synchronizer latency; no correction.
    function automatic logic is_touched(input logic [CNT_W-1:0] rise);
        return rise > CNT_W'(THRESHOLD);
    endfunction

endpackage

// File: rtl/cap_touch_scanner_debounce.sv
// ---------------------------------------------------------------------------
// cap_debounce
//   Per-pad debouncer. Holds the pad's stable state and counts consecutive
//   scans whose raw result disagrees with it; DEBOUNCE_SCANS disagreeing
//   scans in a row flip the stable state. Any agreeing scan clears the count.
// Ports
//   clock   in  system clock
//   reset   in  asynchronous, active-low
//   en      in  one-cycle strobe, high once per scan (EVAL)
//   raw     in  this scan's thresholded result
//   stable  out debounced pad state
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module cap_debounce
    import cap_touch_scanner_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic raw,
    output logic stable
);

    logic [AGREE_W-1:0] agree;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            agree  <= '0;
        end else if (en) begin
            if (raw == stable) begin
                agree <= '0;
            end else if (agree == AGREE_W'(DEBOUNCE_SCANS - 1)) begin
                // This is the DEBOUNCE_SCANS-th disagreeing scan in a row.
                stable <= ~stable;
                agree  <= '0;
            end else begin
                agree <= agree + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cap_touch_scanner.sv
// ---------------------------------------------------------------------------
// cap_touch_scanner
//   Processor-side reader for the 9-pad capacitive array. Discharges the
//   shared charge line, raises it, and times how long each pad's sense input
//   takes to rise. Rise times above THRESHOLD count as touches; per-pad
//   debouncers filter them into touch_mask, and newly pressed pads are
//   latched in press_latched until the processor reads (rd_strobe).
//
// Ports
//   clock                   in   system clock
//   reset                   in   asynchronous, active-low
//   scan_en                 in   1 = scan continuously
//   capacitive_sensors_in   in   pad sense inputs (asynchronous)
//   capacitive_sensors_out  out  shared charge drive (high only in MEASURE)
//   touch_mask              out  debounced held state per pad
//   press_latched           out  sticky newly-pressed bits
//   rd_strobe               in   processor read; clears press_latched
//   scan_done               out  1-cycle pulse per completed scan (EVAL)
//   raw_sel / raw_count     raw rise time of one pad, only with CAP_SCAN_RAW_EN
//   fsm_state               out  current FSM state, for debug/observation
//
// Configuration
//   CAP_SCAN_RAW_EN : adds raw_sel[3:0] in and raw_count[CNT_W-1:0] out.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module cap_touch_scanner
    import cap_touch_scanner_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   scan_en,
    input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
    output logic                   capacitive_sensors_out,
    output logic [NUM_SENSORS-1:0] touch_mask,
    output logic [NUM_SENSORS-1:0] press_latched,
    input  logic                   rd_strobe,
    output logic                   scan_done,
`ifdef CAP_SCAN_RAW_EN
    input  logic [3:0]             raw_sel,
    output logic [CNT_W-1:0]       raw_count,
`endif
    output cap_state_t             fsm_state
);

    cap_state_t             state;
    logic [NUM_SENSORS-1:0] sync_q1;
    logic [NUM_SENSORS-1:0] sync_in;
    logic [DIS_W-1:0]       dis_cnt;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_SENSORS-1:0] done;
    logic [CNT_W-1:0]       rise [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] raw;
    logic [NUM_SENSORS-1:0] stable;
    logic                   timeout;
    logic                   eval;

    assign fsm_state = state;
    assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign eval      = (state == ST_EVAL);

    // Two-flop synchronizer on the asynchronous pad inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_in <= '0;
        end else begin
            sync_q1 <= capacitive_sensors_in;
            sync_in <= sync_q1;
        end
    end

    // Scan FSM with the rise counter and per-pad capture.
    // capacitive_sensors_out and scan_done are registered alongside the
    // state so they are exactly aligned with MEASURE and EVAL respectively.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                  <= ST_IDLE;
            dis_cnt                <= '0;
            cnt                    <= '0;
            done                   <= '0;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++) rise[i] <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    capacitive_sensors_out <= 1'b0;
                    if (scan_en) begin
                        state   <= ST_DISCHARGE;
                        dis_cnt <= '0;
                    end
                end

                ST_DISCHARGE: begin
                    cnt  <= '0;
                    done <= '0;
                    for (int i = 0; i < NUM_SENSORS; i++) rise[i] <= '0;
                    if (dis_cnt == DIS_W'(DISCHARGE_CYCLES - 1)) begin
                        state                  <= ST_MEASURE;
                        capacitive_sensors_out <= 1'b1;
                    end else begin
                        dis_cnt <= dis_cnt + 1'b1;
                    end
                end

                ST_MEASURE: begin
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        if (sync_in[i] && !done[i]) begin
                            rise[i] <= cnt;
                            done[i] <= 1'b1;
                        end else if (timeout && !done[i]) begin
                            // Pad never rose: saturate so it reads as touched.
                            rise[i] <= CNT_W'(TIMEOUT_CYCLES);
                        end
                    end
                    if ((&done) || timeout) begin
                        state                  <= ST_EVAL;
                        capacitive_sensors_out <= 1'b0;
                        scan_done              <= 1'b1;
                    end else begin
                        // Stops at TIMEOUT_CYCLES-1, so cnt never wraps.
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_EVAL: begin
                    // scan_en is only sampled here: a drop mid-scan lets
                    // the current scan finish before returning to IDLE.
                    if (scan_en) begin
                        state   <= ST_DISCHARGE;
                        dis_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_SENSORS; i++) raw[i] = is_touched(rise[i]);
    end

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_debounce
        cap_debounce u_debounce (
            .clock  (clock),
            .reset  (reset),
            .en     (eval),
            .raw    (raw[g]),
            .stable (stable[g])
        );
    end

    // touch_mask trails the debouncers by one cycle, so the rising-edge term
    // (stable & ~touch_mask) is nonzero exactly in the cycle after EVAL.
    // A read clears old latched bits but never a bit being set this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            touch_mask    <= '0;
            press_latched <= '0;
        end else begin
            touch_mask    <= stable;
            press_latched <= (rd_strobe ? '0 : press_latched) | (stable & ~touch_mask);
        end
    end

`ifdef CAP_SCAN_RAW_EN
    logic [CNT_W-1:0] raw_pick;

    // Explicit select keeps out-of-range raw_sel values at zero.
    always_comb begin
        raw_pick = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (raw_sel == 4'(i)) raw_pick = rise[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            raw_count <= '0;
        end else if (eval) begin
            raw_count <= raw_pick;
        end
    end
`endif

endmodule

// File: tb/tb_cap_touch_scanner.sv
`timescale 1ns/1ps
module tb_cap_touch_scanner;
    import cap_touch_scanner_pkg::*;

    localparam int NEVER = 1000000;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             scan_en = 1'b0;
    logic             rd_strobe = 1'b0;
    logic [8:0]       sens_in = '0;
    logic             sens_out;
    logic [8:0]       touch_mask;
    logic [8:0]       press_latched;
    logic             scan_done;
    cap_state_t       fsm_state;
`ifdef CAP_SCAN_RAW_EN
    logic [3:0]       raw_sel = '0;
    logic [CNT_W-1:0] raw_count;
`endif

    int total = 0;
    int bad   = 0;

    // Target measured rise count per pad (count includes sync latency).
    int pad_rise [9];
    int meas_m = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    cap_touch_scanner dut (
        .clock                  (clock),
        .reset                  (reset),
        .scan_en                (scan_en),
        .capacitive_sensors_in  (sens_in),
        .capacitive_sensors_out (sens_out),
        .touch_mask             (touch_mask),
        .press_latched          (press_latched),
        .rd_strobe              (rd_strobe),
        .scan_done              (scan_done),
`ifdef CAP_SCAN_RAW_EN
        .raw_sel                (raw_sel),
        .raw_count              (raw_count),
`endif
        .fsm_state              (fsm_state)
    );

    // Pad model: the pad input goes high in the (target-2)th charge cycle so
    // that, after the 2-flop synchronizer, the captured count equals target.
    always @(negedge clock) begin
        if (sens_out) begin
            for (int i = 0; i < 9; i++) sens_in[i] = (meas_m >= pad_rise[i] - 2);
            meas_m = meas_m + 1;
        end else begin
            sens_in = '0;
            meas_m  = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_all(input int v);
        for (int i = 0; i < 9; i++) pad_rise[i] = v;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        scan_en = 1'b0;
        rd_strobe = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Returns at the negedge where the n-th scan_done pulse is seen (EVAL).
    task automatic wait_scans(input int n, output bit ok);
        int seen = 0;
        for (int c = 0; c < 30000 && seen < n; c++) begin
            @(negedge clock);
            if (scan_done) seen++;
        end
        ok = (seen == n);
    endtask

    // From EVAL: debouncer updates at the next edge, touch_mask one later.
    task automatic settle();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_state(input cap_state_t s, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge clock);
            if (fsm_state == s) ok = 1'b1;
        end
    endtask

    // Counts MEASURE cycles of the next scan; returns in the following EVAL.
    task automatic measure_len(output int len, output bit ok);
        wait_state(ST_MEASURE, ok);
        len = 0;
        while (ok && fsm_state == ST_MEASURE && len < 5000) begin
            len++;
            @(negedge clock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (sens_out !== 1'b0) begin bad++; $display("FAIL reset_out: got %0b want 0", sens_out); end
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL reset_mask: got %0h want 0", touch_mask); end
        total++; if (press_latched !== 9'h000) begin bad++; $display("FAIL reset_press: got %0h want 0", press_latched); end
        total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", scan_done); end
        total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        reset = 1'b1;
        repeat (10) @(negedge clock);
        total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL idle_hold: got %0d want 0", fsm_state); end
    endtask

    task automatic test_no_touch();
        bit ok; int len;
        apply_reset();
        set_all(50);
        scan_en = 1'b1;
        measure_len(len, ok);
        total++; if (!ok) begin bad++; $display("FAIL notouch_measure: got timeout want MEASURE"); end
        total++; if (len != 52) begin bad++; $display("FAIL notouch_len: got %0d want 52", len); end
        total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL notouch_done1: got %0b want 1", scan_done); end
        wait_scans(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL notouch_done2: got timeout want scan_done"); end
        settle();
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL notouch_mask: got %0h want 0", touch_mask); end
        total++; if (press_latched !== 9'h000) begin bad++; $display("FAIL notouch_press: got %0h want 0", press_latched); end
    endtask

    task automatic test_touch();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[4] = 300;
        scan_en = 1'b1;
        wait_scans(2, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h000) begin bad++; $display("FAIL touch_2scans: got %0h ok=%0b want 0", touch_mask, ok); end
        wait_scans(1, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h010) begin bad++; $display("FAIL touch_mask: got %0h ok=%0b want 010", touch_mask, ok); end
        total++; if (press_latched !== 9'h010) begin bad++; $display("FAIL touch_press: got %0h want 010", press_latched); end
        rd_strobe = 1'b1;
        @(negedge clock);
        rd_strobe = 1'b0;
        total++; if (press_latched !== 9'h000) begin bad++; $display("FAIL touch_rd_clear: got %0h want 0", press_latched); end
        total++; if (touch_mask !== 9'h010) begin bad++; $display("FAIL touch_rd_mask: got %0h want 010", touch_mask); end
        // Release: two scans keep the pad held, the third drops it.
        pad_rise[4] = 50;
        wait_scans(2, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h010) begin bad++; $display("FAIL release_2scans: got %0h ok=%0b want 010", touch_mask, ok); end
        wait_scans(1, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h000) begin bad++; $display("FAIL release_mask: got %0h ok=%0b want 0", touch_mask, ok); end
        total++; if (press_latched !== 9'h000) begin bad++; $display("FAIL release_press: got %0h want 0", press_latched); end
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[4] = 300;
        scan_en = 1'b1;
        wait_scans(3, ok);
        settle();
        wait_state(ST_MEASURE, ok);
        repeat (10) @(negedge clock);
        total++; if (!ok || sens_out !== 1'b1 || touch_mask !== 9'h010) begin
            bad++; $display("FAIL areset_pre: got out=%0b mask=%0h want 1 010", sens_out, touch_mask);
        end
        #2 reset = 1'b0;
        #1;
        total++; if (sens_out !== 1'b0) begin bad++; $display("FAIL areset_out: got %0b want 0", sens_out); end
        total++; if (touch_mask !== 9'h000) begin bad++; $display("FAIL areset_mask: got %0h want 0", touch_mask); end
        total++; if (press_latched !== 9'h000) begin bad++; $display("FAIL areset_press: got %0h want 0", press_latched); end
        total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL areset_state: got %0d want 0", fsm_state); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_bounce();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[0] = 300;
        scan_en = 1'b1;
        wait_scans(2, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h000) begin bad++; $display("FAIL bounce_2: got %0h ok=%0b want 0", touch_mask, ok); end
        pad_rise[0] = 50;
        wait_scans(1, ok);
        pad_rise[0] = 300;
        wait_scans(2, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h000) begin bad++; $display("FAIL bounce_reset: got %0h ok=%0b want 0", touch_mask, ok); end
        wait_scans(1, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h001) begin bad++; $display("FAIL bounce_flip: got %0h ok=%0b want 001", touch_mask, ok); end
        total++; if (press_latched !== 9'h001) begin bad++; $display("FAIL bounce_press: got %0h want 001", press_latched); end
    endtask

    task automatic test_threshold();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[1] = 200;
        pad_rise[3] = 201;
        scan_en = 1'b1;
        wait_scans(3, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h008) begin bad++; $display("FAIL threshold: got %0h ok=%0b want 008", touch_mask, ok); end
    endtask

    task automatic test_timeout();
        bit ok; int len;
        apply_reset();
        set_all(50);
        pad_rise[8] = NEVER;
        scan_en = 1'b1;
        measure_len(len, ok);
        total++; if (!ok || len != TIMEOUT_CYCLES) begin bad++; $display("FAIL timeout_len: got %0d want %0d", len, TIMEOUT_CYCLES); end
        total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL timeout_done: got %0b want 1", scan_done); end
        wait_scans(2, ok);
        settle();
        total++; if (!ok || touch_mask !== 9'h100) begin bad++; $display("FAIL timeout_mask: got %0h ok=%0b want 100", touch_mask, ok); end
    endtask

    task automatic test_collision();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[5] = 300;
        scan_en = 1'b1;
        wait_scans(1, ok);
        pad_rise[2] = 300;
        wait_scans(2, ok);
        settle();
        total++; if (!ok || press_latched !== 9'h020) begin bad++; $display("FAIL collide_pre: got %0h ok=%0b want 020", press_latched, ok); end
        wait_scans(1, ok);
        @(negedge clock);
        rd_strobe = 1'b1;
        @(negedge clock);
        rd_strobe = 1'b0;
        total++; if (!ok || press_latched !== 9'h004) begin bad++; $display("FAIL collide_press: got %0h ok=%0b want 004", press_latched, ok); end
        total++; if (touch_mask !== 9'h024) begin bad++; $display("FAIL collide_mask: got %0h want 024", touch_mask); end
    endtask

    task automatic test_scan_en_drop();
        bit ok; int pulses;
        apply_reset();
        set_all(50);
        scan_en = 1'b1;
        wait_state(ST_MEASURE, ok);
        scan_en = 1'b0;
        wait_scans(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_done: got timeout want scan_done"); end
        @(negedge clock);
        total++; if (fsm_state !== ST_IDLE || sens_out !== 1'b0) begin
            bad++; $display("FAIL drop_idle: got state=%0d out=%0b want 0 0", fsm_state, sens_out);
        end
        pulses = 0;
        repeat (100) begin
            @(negedge clock);
            if (scan_done) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL drop_quiet: got %0d pulses want 0", pulses); end
    endtask

`ifdef CAP_SCAN_RAW_EN
    task automatic test_raw();
        bit ok;
        apply_reset();
        set_all(50);
        pad_rise[4] = 300;
        raw_sel = 4'd4;
        scan_en = 1'b1;
        wait_scans(1, ok);
        @(negedge clock);
        total++; if (!ok || raw_count !== CNT_W'(300)) begin bad++; $display("FAIL raw_pad4: got %0d want 300", raw_count); end
        raw_sel = 4'd12;
        wait_scans(1, ok);
        @(negedge clock);
        total++; if (!ok || raw_count !== '0) begin bad++; $display("FAIL raw_sel12: got %0d want 0", raw_count); end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        set_all(50);
        test_reset();
        test_no_touch();
        test_touch();
        test_async_reset();
        test_bounce();
        test_threshold();
        test_timeout();
        test_collision();
        test_scan_en_drop();
`ifdef CAP_SCAN_RAW_EN
        test_raw();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
